// File: rtl/alu_seq_if.sv
// Request/result handshake bundle for alu_seq.
// The slave side is the ALU; the master side is the requester/consumer.
interface alu_seq_if #(
  parameter int BITS = 8
) ();
  logic            i_valid;
  logic            o_ready;
  logic [BITS-1:0] i_a;
  logic [BITS-1:0] i_b;
  logic [2:0]      i_op;
  logic            o_valid;
  logic            i_ready;
  logic [BITS-1:0] o_out;
  logic [3:0]      o_status;

  modport master (
    output i_valid, i_a, i_b, i_op, i_ready,
    input  o_ready, o_valid, o_out, o_status
  );

  modport slave (
    input  i_valid, i_a, i_b, i_op, i_ready,
    output o_ready, o_valid, o_out, o_status
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle SUB/CMP/SHL/CHG/ADD, iterative shift-add MUL.
// Optional feature macro: ALU_SEQ_MUL_EN (defined -> opcode 101 is MUL,
// undefined -> no BUSY state, no multiplier, opcode 101 is illegal).
// Status flags: [0] ERROR, [1] EVEN zero-count, [2] OVF, [3] SINGLE zero.
//
// state  | meaning
// S_IDLE | waiting for a request, o_ready high
// S_BUSY | MUL shift-add iterations in progress, o_ready low
// S_DONE | result held on o_out/o_status, o_valid high
module alu_seq #(
  parameter int BITS = 8
) (
  input  logic      i_clk,
  input  logic      i_rst,
  alu_seq_if.slave  bus
);

  localparam logic [BITS:0]   BITS_V = (BITS+1)'(BITS);
  localparam logic [BITS-1:0] ONE    = BITS'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
`ifdef ALU_SEQ_MUL_EN
    S_BUSY = 2'd1,
`endif
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [BITS-1:0] out_q, out_d;
  logic [3:0]      status_q, status_d;

  logic            accept;
  logic            b_big;
  logic [BITS-1:0] alu_out;
  logic            alu_err;
  logic            alu_ovf;
  logic [BITS:0]   wide;
  logic [2*BITS-1:0] shl;

`ifdef ALU_SEQ_MUL_EN
  localparam int CW = $clog2(BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(BITS-1);

  logic              is_mul;
  logic [2*BITS-1:0] acc_q, acc_d;
  logic [2*BITS-1:0] mcand_q, mcand_d;
  logic [BITS-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*BITS-1:0] acc_step;

  assign is_mul   = (bus.i_op == 3'b101);
  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif

  // EVEN/SINGLE derive from the number of zero bits in the final result
  function automatic logic [3:0] make_status(logic [BITS-1:0] res, logic err, logic ovf);
    int unsigned zeros;
    zeros = 0;
    for (int i = 0; i < BITS; i++) begin
      if (!res[i]) zeros++;
    end
    return {zeros == 1, ovf, zeros[0] == 1'b0, err};
  endfunction

  assign bus.o_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && bus.i_ready);
  assign accept       = bus.i_valid && bus.o_ready;
  assign bus.o_valid  = (state_q == S_DONE);
  assign bus.o_out    = out_q;
  assign bus.o_status = status_q;

  // Out-of-range shift amount / bit index
  assign b_big = {1'b0, bus.i_b} >= BITS_V;

  // Single-cycle result from the live operands, registered on acceptance
  always_comb begin
    alu_out = '0;
    alu_err = 1'b0;
    alu_ovf = 1'b0;
    wide    = '0;
    shl     = '0;
    case (bus.i_op)
      3'b000: begin
        wide    = {1'b0, bus.i_a} - {1'b0, bus.i_b};
        alu_out = wide[BITS-1:0];
        alu_ovf = bus.i_a < bus.i_b;
      end
      3'b001: alu_out = {{(BITS-1){1'b0}}, bus.i_a > bus.i_b};
      3'b010: begin
        if (b_big) begin
          alu_err = 1'b1;
        end else begin
          shl     = {{BITS{1'b0}}, bus.i_a} << bus.i_b;
          alu_out = shl[BITS-1:0];
          alu_ovf = |shl[2*BITS-1:BITS];
        end
      end
      3'b011: begin
        if (b_big) begin
          alu_out = bus.i_a;
          alu_err = 1'b1;
        end else begin
          alu_out = bus.i_a ^ (ONE << bus.i_b);
        end
      end
      3'b100: begin
        wide    = {1'b0, bus.i_a} + {1'b0, bus.i_b};
        alu_out = wide[BITS-1:0];
        alu_ovf = wide[BITS];
      end
      default: alu_err = 1'b1;
    endcase
  end

  // Next-state, result load and multiplier iteration
  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    status_d = status_q;
`ifdef ALU_SEQ_MUL_EN
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
`ifdef ALU_SEQ_MUL_EN
          if (is_mul) begin
            state_d  = S_BUSY;
            acc_d    = '0;
            mcand_d  = {{BITS{1'b0}}, bus.i_a};
            mplier_d = bus.i_b;
            cnt_d    = CNT_LAST;
          end else
`endif
          begin
            state_d  = S_DONE;
            out_d    = alu_out;
            status_d = make_status(alu_out, alu_err, alu_ovf);
          end
        end else if ((state_q == S_DONE) && bus.i_ready) begin
          state_d = S_IDLE;
        end
      end
`ifdef ALU_SEQ_MUL_EN
      S_BUSY: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d  = S_DONE;
          out_d    = acc_step[BITS-1:0];
          status_d = make_status(acc_step[BITS-1:0], 1'b0, |acc_step[2*BITS-1:BITS]);
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Result and multiplier registers; reset discards any operation in flight
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      out_q    <= '0;
      status_q <= '0;
`ifdef ALU_SEQ_MUL_EN
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      out_q    <= out_d;
      status_q <= status_d;
`ifdef ALU_SEQ_MUL_EN
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (BITS=8), valid in both ALU_SEQ_MUL_EN builds.
module tb_alu_seq;
  localparam int BITS = 8;
`ifdef ALU_SEQ_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  alu_seq_if #(.BITS(BITS)) bus ();
  alu_seq #(.BITS(BITS)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Reference: {latency[3:0], SINGLE, OVF, EVEN, ERROR, out[7:0]}
  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    int r, z, lat;
    bit err, ovf;
    logic [7:0] o;
    logic [3:0] l4;
    r = 0; err = 0; ovf = 0; lat = 1;
    case (op)
      3'd0: begin r = int'(a) - int'(b); if (r < 0) begin ovf = 1; r += 256; end end
      3'd1: r = (a > b) ? 1 : 0;
      3'd2: if (b >= 8) err = 1; else begin r = int'(a) * (1 << b); ovf = (r > 255); end
      3'd3: if (b >= 8) begin r = int'(a); err = 1; end else r = int'(a) ^ (1 << b);
      3'd4: begin r = int'(a) + int'(b); ovf = (r > 255); end
      3'd5: if (MUL_EN) begin r = int'(a) * int'(b); ovf = (r > 255); lat = BITS + 1; end
            else err = 1;
      default: err = 1;
    endcase
    o  = r[7:0];
    z  = 8 - $countones(o);
    l4 = lat[3:0];
    return {l4, (z == 1), ovf, (z % 2 == 0), err, o};
  endfunction

  // Offer one request from IDLE, scramble inputs afterwards, wait for the result, consume it
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        output int lat, output logic [7:0] out, output logic [3:0] st,
                        output logic rdy_offer, output logic rdy_busy);
    bus.i_valid = 1'b1; bus.i_a = a; bus.i_b = b; bus.i_op = op; bus.i_ready = 1'b0;
    rdy_offer = bus.o_ready;
    rdy_busy  = 1'b0;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    bus.i_a = 8'($urandom); bus.i_b = 8'($urandom); bus.i_op = 3'($urandom);
    lat = 1;
    while (!bus.o_valid && lat < 40) begin
      if (bus.o_ready) rdy_busy = 1'b1;
      @(posedge clk); #1;
      lat++;
      bus.i_a = 8'($urandom); bus.i_b = 8'($urandom); bus.i_op = 3'($urandom);
    end
    out = bus.o_out;
    st  = bus.o_status;
    bus.i_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_valid = 1'b0; bus.i_ready = 1'b0; bus.i_a = '0; bus.i_b = '0; bus.i_op = '0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (bus.o_valid !== 1'b0) $display("FAIL rst_valid: got %b expected 0", bus.o_valid); else pass_cnt++;
    total_cnt++;
    if (bus.o_out !== 8'h00) $display("FAIL rst_out: got %h expected 00", bus.o_out); else pass_cnt++;
    total_cnt++;
    if (bus.o_status !== 4'h0) $display("FAIL rst_status: got %h expected 0", bus.o_status); else pass_cnt++;
    rst = 1'b0;
    #1;
    total_cnt++;
    if (bus.o_ready !== 1'b1) $display("FAIL rst_ready: got %b expected 1", bus.o_ready); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  logic [7:0] da [10];
  logic [7:0] db [10];
  logic [2:0] dop [10];
  logic [7:0] eo [10];
  logic [3:0] es [10];
  int         el [10];

  task automatic test_directed();
    int lat; logic [7:0] out; logic [3:0] st; logic ro, rb;
    da  = '{8'h03, 8'h81, 8'h81, 8'h07, 8'hFF, 8'h00, 8'h55, 8'hA5, 8'd16, 8'h02};
    db  = '{8'h05, 8'h01, 8'h08, 8'h02, 8'h01, 8'h03, 8'h09, 8'h5A, 8'd17, 8'h07};
    dop = '{3'd0,  3'd2,  3'd2,  3'd1,  3'd4,  3'd3,  3'd3,  3'd6,  3'd5,  3'd1};
    eo  = '{8'hFE, 8'h02, 8'h00, 8'h01, 8'h00, 8'h08, 8'h55, 8'h00, 8'h00, 8'h00};
    es  = '{4'hC,  4'h4,  4'h3,  4'h0,  4'h6,  4'h0,  4'h3,  4'h3,  4'h3,  4'h2};
    el  = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    if (MUL_EN) begin
      eo[8] = 8'h10; es[8] = 4'h4; el[8] = 9;
    end
    for (int i = 0; i < 10; i++) begin
      run_op(da[i], db[i], dop[i], lat, out, st, ro, rb);
      total_cnt++;
      if (ro !== 1'b1) $display("FAIL dir_ready_idle[%0d]: got %b expected 1", i, ro); else pass_cnt++;
      total_cnt++;
      if (out !== eo[i]) $display("FAIL dir_out[%0d]: got %h expected %h", i, out, eo[i]); else pass_cnt++;
      total_cnt++;
      if (st !== es[i]) $display("FAIL dir_status[%0d]: got %h expected %h", i, st, es[i]); else pass_cnt++;
      total_cnt++;
      if (lat != el[i]) $display("FAIL dir_latency[%0d]: got %0d expected %0d", i, lat, el[i]); else pass_cnt++;
      total_cnt++;
      if (rb !== 1'b0) $display("FAIL dir_ready_busy[%0d]: got %b expected 0", i, rb); else pass_cnt++;
    end
  endtask

  task automatic test_random();
    int lat; logic [7:0] out, a, b; logic [3:0] st; logic [2:0] op; logic ro, rb;
    logic [15:0] exp;
    for (int i = 0; i < 150; i++) begin
      a  = 8'($urandom);
      b  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 11)) : 8'($urandom);
      op = 3'($urandom_range(0, 7));
      exp = model(a, b, op);
      run_op(a, b, op, lat, out, st, ro, rb);
      total_cnt++;
      if (out !== exp[7:0])
        $display("FAIL rnd_out[%0d] op=%0d a=%h b=%h: got %h expected %h", i, op, a, b, out, exp[7:0]);
      else pass_cnt++;
      total_cnt++;
      if (st !== exp[11:8])
        $display("FAIL rnd_status[%0d] op=%0d a=%h b=%h: got %h expected %h", i, op, a, b, st, exp[11:8]);
      else pass_cnt++;
      total_cnt++;
      if (lat != int'(exp[15:12]) || rb !== 1'b0)
        $display("FAIL rnd_latency[%0d] op=%0d: got %0d (ready_busy %b) expected %0d", i, op, lat, rb, exp[15:12]);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp;
    int lat;
    bus.i_valid = 1'b1; bus.i_a = 8'hFF; bus.i_b = 8'h01; bus.i_op = 3'd4; bus.i_ready = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      total_cnt++;
      if (bus.o_valid !== 1'b1 || bus.o_out !== 8'h00 || bus.o_status !== 4'h6 || bus.o_ready !== 1'b0)
        $display("FAIL hold[%0d]: got v=%b out=%h st=%h rdy=%b expected v=1 out=00 st=6 rdy=0",
                 k, bus.o_valid, bus.o_out, bus.o_status, bus.o_ready);
      else pass_cnt++;
      bus.i_valid = 1'b1;
      bus.i_a = 8'($urandom); bus.i_b = 8'($urandom); bus.i_op = 3'($urandom);
      @(posedge clk); #1;
    end
    total_cnt++;
    if (bus.o_out !== 8'h00 || bus.o_status !== 4'h6)
      $display("FAIL hold_end: got out=%h st=%h expected out=00 st=6", bus.o_out, bus.o_status);
    else pass_cnt++;
    bus.i_ready = 1'b1; bus.i_valid = 1'b1; bus.i_a = 8'h00; bus.i_b = 8'h03; bus.i_op = 3'd3;
    #1;
    total_cnt++;
    if (bus.o_ready !== 1'b1) $display("FAIL b2b_ready: got %b expected 1", bus.o_ready); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (bus.o_valid !== 1'b1 || bus.o_out !== 8'h08 || bus.o_status !== 4'h0)
      $display("FAIL b2b_chg: got v=%b out=%h st=%h expected v=1 out=08 st=0",
               bus.o_valid, bus.o_out, bus.o_status);
    else pass_cnt++;
    exp = model(8'd3, 8'd5, 3'd5);
    bus.i_ready = 1'b1; bus.i_valid = 1'b1; bus.i_a = 8'd3; bus.i_b = 8'd5; bus.i_op = 3'd5;
    @(posedge clk); #1;
    bus.i_valid = 1'b0; bus.i_ready = 1'b0;
    lat = 1;
    while (!bus.o_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    total_cnt++;
    if (bus.o_out !== exp[7:0] || bus.o_status !== exp[11:8] || lat != int'(exp[15:12]))
      $display("FAIL b2b_second: got out=%h st=%h lat=%0d expected out=%h st=%h lat=%0d",
               bus.o_out, bus.o_status, lat, exp[7:0], exp[11:8], exp[15:12]);
    else pass_cnt++;
    bus.i_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_ready = 1'b0;
    total_cnt++;
    if (bus.o_valid !== 1'b0) $display("FAIL b2b_drain: got %b expected 0", bus.o_valid); else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    int lat; logic [7:0] out; logic [3:0] st; logic ro, rb;
    run_op(8'd7, 8'd2, 3'd1, lat, out, st, ro, rb);
    if (MUL_EN) begin
      bus.i_valid = 1'b1; bus.i_a = 8'd16; bus.i_b = 8'd17; bus.i_op = 3'd5; bus.i_ready = 1'b0;
      @(posedge clk); #1;
      bus.i_valid = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
    end else begin
      bus.i_valid = 1'b1; bus.i_a = 8'd3; bus.i_b = 8'd5; bus.i_op = 3'd0; bus.i_ready = 1'b0;
      @(posedge clk); #1;
      bus.i_valid = 1'b0;
    end
    rst = 1'b1;
    #1;
    total_cnt++;
    if (bus.o_valid !== 1'b0 || bus.o_out !== 8'h00 || bus.o_status !== 4'h0)
      $display("FAIL abort_clear: got v=%b out=%h st=%h expected v=0 out=00 st=0",
               bus.o_valid, bus.o_out, bus.o_status);
    else pass_cnt++;
    #3 rst = 1'b0;
    #1;
    total_cnt++;
    if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0)
      $display("FAIL abort_ready: got rdy=%b v=%b expected rdy=1 v=0", bus.o_ready, bus.o_valid);
    else pass_cnt++;
    run_op(8'd7, 8'd2, 3'd1, lat, out, st, ro, rb);
    total_cnt++;
    if (out !== 8'h01 || st !== 4'h0 || lat != 1)
      $display("FAIL abort_next_cmp: got out=%h st=%h lat=%0d expected out=01 st=0 lat=1", out, st, lat);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
